// File: rtl/bcd_to_binary_pkg.sv
// Shared definitions for the BCD-to-binary converter: FSM encoding,
// default geometry and the largest representable result.
package bcd_to_binary_pkg;

   localparam int DIGITS = 8;
   localparam int WIDTH  = 26;

   // Largest value binaryValue can carry without saturating (2^WIDTH-1).
   localparam logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   // A BCD nibble above 9 has no decimal meaning.
   function automatic logic is_bad_digit(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter. Digits are latched on start and
// folded MSD first with acc = acc*10 + digit, one digit per clock.
// The result saturates to all ones when it does not fit in WIDTH bits.
module bcd_to_binary #(
   parameter int DIGITS = bcd_to_binary_pkg::DIGITS,
   parameter int WIDTH  = bcd_to_binary_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       digit7,
   input  logic [3:0]       digit6,
   input  logic [3:0]       digit5,
   input  logic [3:0]       digit4,
   input  logic [3:0]       digit3,
   input  logic [3:0]       digit2,
   input  logic [3:0]       digit1,
   input  logic [3:0]       digit0,
   output logic [WIDTH-1:0] binaryValue,
   output logic             ready,
   output logic             done,
   output logic             overflow,
   output logic             invalid
);

   import bcd_to_binary_pkg::*;

   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);
   // One extra accumulator bit so an all-nines input cannot wrap.
   localparam logic [WIDTH:0]   ACC_MAX  = {1'b0, {WIDTH{1'b1}}};

   state_t              state;
   state_t              state_nxt;
   logic [4*DIGITS-1:0] digits_q;
   logic [WIDTH:0]      acc;
   logic [WIDTH:0]      acc_nxt;
   logic [CNT_W-1:0]    count;
   logic                bad_q;
   logic [3:0]          cur_digit;
   logic                last_step;
   logic [31:0]         digit_bus;

   // Clamp the wide accumulator to the output width.
   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] a);
      return (a > ACC_MAX) ? {WIDTH{1'b1}} : a[WIDTH-1:0];
   endfunction

   // Flag any non-decimal nibble in the digit word being latched.
   function automatic logic any_bad(input logic [4*DIGITS-1:0] d);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         bad = bad | is_bad_digit(d[4*i +: 4]);
      end
      return bad;
   endfunction

   assign digit_bus = {digit7, digit6, digit5, digit4,
                       digit3, digit2, digit1, digit0};

   // The latched word shifts left each step, so its top nibble is always
   // the digit selected by the count (MSD first).
   assign cur_digit = digits_q[4*DIGITS-1 -: 4];
   assign acc_nxt   = (acc << 3) + (acc << 1) + {{(WIDTH-3){1'b0}}, cur_digit};
   assign last_step = (state == ST_CONVERT) && (count == LAST_CNT);

   // State register; reset wins over everything, including start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            if (count == LAST_CNT) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Digit latch, multiply-accumulate and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q    <= '0;
         acc         <= '0;
         count       <= '0;
         bad_q       <= 1'b0;
         binaryValue <= '0;
         overflow    <= 1'b0;
         invalid     <= 1'b0;
      end else if (state == ST_IDLE) begin
         if (start) begin
            digits_q <= digit_bus[4*DIGITS-1:0];
            bad_q    <= any_bad(digit_bus[4*DIGITS-1:0]);
            acc      <= '0;
            count    <= '0;
         end
      end else if (state == ST_CONVERT) begin
         acc      <= acc_nxt;
         digits_q <= digits_q << 4;
         count    <= count + 1'b1;
         if (last_step) begin
            binaryValue <= saturate(acc_nxt);
            overflow    <= (acc_nxt > ACC_MAX);
            invalid     <= bad_q;
         end
      end
   end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: hand-computed vectors covering reset,
// normal conversions, the saturation boundary, invalid digits, abort by
// reset, ignored start/digit changes and back-to-back conversions.
module tb_bcd_to_binary;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0;
   logic [25:0] binaryValue;
   logic        ready;
   logic        done;
   logic        overflow;
   logic        invalid;

   int n_vec = 0;
   int n_bad = 0;

   bcd_to_binary dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .digit7      (digit7),
      .digit6      (digit6),
      .digit5      (digit5),
      .digit4      (digit4),
      .digit3      (digit3),
      .digit2      (digit2),
      .digit1      (digit1),
      .digit0      (digit0),
      .binaryValue (binaryValue),
      .ready       (ready),
      .done        (done),
      .overflow    (overflow),
      .invalid     (invalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic set_digits(input logic [31:0] b);
      {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0} = b;
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge after
   // the accepting edge k (cycle offset 0).
   task automatic launch(input logic [31:0] b);
      set_digits(b);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Steps negedges until done is seen, counting cycles; bounded.
   task automatic wait_done(output int m);
      m = 0;
      while (done !== 1'b1 && m < 20) begin
         @(negedge clk);
         m++;
      end
   endtask

   task automatic count_done(input int cycles, output int pulses);
      pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
   endtask

   task automatic convert(input string tag, input logic [31:0] b, input logic [31:0] exp_val,
                          input logic exp_ovf, input logic exp_inv);
      int m;
      launch(b);
      chk({tag, "_busy"}, {31'b0, ready}, 32'd0);
      wait_done(m);
      chk({tag, "_latency"}, m, 32'd8);
      chk({tag, "_value"}, {6'b0, binaryValue}, exp_val);
      chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, exp_ovf});
      chk({tag, "_inv"}, {31'b0, invalid}, {31'b0, exp_inv});
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
      chk({tag, "_ready_back"}, {31'b0, ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int m;
      int pulses;
      int first_j;
      int prev_j;
      int gap_bad;

      rst   = 1'b1;
      start = 1'b0;
      set_digits(32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'b0, ready}, 32'd1);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_value", {6'b0, binaryValue}, 32'd0);
      chk("rst_ovf", {31'b0, overflow}, 32'd0);
      chk("rst_inv", {31'b0, invalid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      convert("basic", 32'h00123456, 32'd123456, 1'b0, 1'b0);
      convert("max_exact", 32'h67108863, 32'd67108863, 1'b0, 1'b0);
      convert("all_nines", 32'h99999999, 32'h03FFFFFF, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      chk("hold_value", {6'b0, binaryValue}, 32'h03FFFFFF);
      chk("hold_ovf", {31'b0, overflow}, 32'd1);

      convert("bad_digit", 32'h0000C000, 32'd12000, 1'b0, 1'b1);

      // Abort by reset at edge k+4.
      launch(32'h00000777);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", {31'b0, ready}, 32'd1);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_value", {6'b0, binaryValue}, 32'd0);
      chk("abort_ovf", {31'b0, overflow}, 32'd0);
      chk("abort_inv", {31'b0, invalid}, 32'd0);
      count_done(12, pulses);
      chk("abort_no_done", pulses, 32'd0);
      convert("after_abort", 32'h00000042, 32'd42, 1'b0, 1'b0);

      // Digit change at k+2 and a start pulse at k+3 must both be ignored.
      launch(32'h00123456);
      @(negedge clk);
      set_digits(32'h99999999);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(m);
      chk("ignore_latency", m + 3, 32'd8);
      chk("ignore_value", {6'b0, binaryValue}, 32'd123456);
      chk("ignore_ovf", {31'b0, overflow}, 32'd0);
      count_done(12, pulses);
      chk("ignore_no_queue", pulses, 32'd0);

      // start held high for 30 cycles with all-zero digits.
      set_digits(32'h0);
      start   = 1'b1;
      pulses  = 0;
      first_j = -1;
      prev_j  = -1;
      gap_bad = 0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (first_j < 0) first_j = j;
            else if (j - prev_j != 10) gap_bad++;
            prev_j = j;
         end
      end
      start = 1'b0;
      chk("held_pulses", pulses, 32'd3);
      chk("held_first", first_j, 32'd8);
      chk("held_gaps", gap_bad, 32'd0);
      chk("held_value", {6'b0, binaryValue}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("held_idle", {31'b0, ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
